piso_ser: RTL
=============

PISO_SER -- requirements
Module: piso_ser

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = serialize MSB first, 0 = LSB first.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 d  input  WIDTH  parallel word from the upstream parallel-in/parallel-out register q output.
REQ-006 load  input  1  request to capture d; sampled only when ready=1.
REQ-007 ready  output  1  block idle and able to accept a word.
REQ-008 sout  output  1  serial data bit.
REQ-009 sout_valid  output  1  sout carries a valid bit this cycle.
REQ-010 done  output  1  one-cycle pulse marking the final serial bit of a word.

Function
REQ-011 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-012 The FSM SHALL have states IDLE, SHIFT and PARITY, with PARITY present only under PISO_PARITY_EN.
- IDLE: ready=1, sout=0, sout_valid=0, done=0.
REQ-013 In IDLE, a rising edge with load=1 SHALL capture d into the shift register, load the bit counter with WIDTH-1, and enter SHIFT.
REQ-014 In SHIFT, sout SHALL present one bit per cycle and sout_valid SHALL be 1.
- Ordering: d[WIDTH-1] down to d[0] when MSB_FIRST=1; d[0] up to d[WIDTH-1] when MSB_FIRST=0.
REQ-015 Latency SHALL be one cycle: the first bit appears in the cycle immediately after the capturing edge.
REQ-016 The counter SHALL decrement once per SHIFT cycle.
- On the edge where the counter reaches 0, the FSM SHALL go to IDLE, or to PARITY when parity is enabled.
REQ-017 done SHALL equal 1 only in the cycle presenting the last bit of a word: the last data bit, or the parity bit when parity is enabled.
REQ-018 ready SHALL be 0 in SHIFT and PARITY.
- load in these states SHALL be ignored, with no effect on the shift register, counter or outputs.
REQ-019 Throughput SHALL be one word per WIDTH+1 cycles (WIDTH+2 with parity).
- Earliest next capture: the edge ending the first IDLE cycle after the last bit.
REQ-020 The value of d while load=0 or ready=0 SHALL have no effect.
REQ-021 An all-zero or all-one word SHALL serialize normally; word content has no special cases.

Reset
REQ-022 rst=0 SHALL immediately force IDLE and clear the outputs, independent of clk.
- Cleared: sout=0, sout_valid=0, done=0.
- Set: ready=1.
- Shift register and counter SHALL be cleared.
REQ-023 Reset mid-word SHALL abort the word, discard its remaining bits, and produce no done pulse.
REQ-024 After rst returns to 1, the first rising edge with load=1 SHALL start a clean word.

Configuration
REQ-025 Macro PISO_PARITY_EN.
- When defined: after the last data bit, one PARITY cycle SHALL present the even-parity bit (XOR of the captured word) with sout_valid=1 and done=1.
- When undefined: no PARITY state and no parity logic; done accompanies the last data bit.

Verification
REQ-026 The bench SHALL use a clk period of 100 ns and cover the scenarios below.
- Reset: rst=0 with load=1, d=4'b1111 -> ready=1, sout=0, sout_valid=0, done=0 throughout; no capture.
- Basic word: rst=1, load pulse with d=4'b1010, MSB_FIRST=1 -> sout=1,0,1,0 on cycles 1-4 after capture; sout_valid=1 on cycles 1-4; done=1 on cycle 4 only; ready=1 on cycle 5.
- Ignored load: capture d=4'b1100, then load=1 with d=4'b0101 during SHIFT -> stream stays 1,1,0,0 and ready stays 0 until after the last bit.
- Reset mid-word: capture d=4'b0011, drop rst after 2 bits -> outputs cleared immediately and no done; then load d=4'b0011 -> clean stream 0,0,1,1.
- LSB first: MSB_FIRST=0, d=4'b1100 -> sout=0,0,1,1.
- Parity: PISO_PARITY_EN defined, d=4'b1011 -> sout=1,0,1,1 then parity bit 1; done only on the parity cycle; ready returns one cycle later.

Source files
------------

// File: rtl/piso_ser.sv
// Parallel-in serial-out shifter: captures a word when idle and streams it one bit per cycle.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_ser #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             load,
   output logic             ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
   logic par;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;

   // Bit to present next and the remainder, both for a fresh capture and mid-word.
   logic             nbit_d, nbit_s;
   logic [WIDTH-1:0] rest_d, rest_s;

   always_comb begin
      nbit_d = 1'b0;
      nbit_s = 1'b0;
      rest_d = '0;
      rest_s = '0;
      if (MSB_FIRST) begin
         nbit_d = d[WIDTH-1];
         rest_d = d << 1;
         nbit_s = sreg[WIDTH-1];
         rest_s = sreg << 1;
      end else begin
         nbit_d = d[0];
         rest_d = d >> 1;
         nbit_s = sreg[0];
         rest_s = sreg >> 1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         sreg       <= '0;
         cnt        <= '0;
         ready      <= 1'b1;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         done       <= 1'b0;
`ifdef PISO_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  state      <= SHIFT;
                  sreg       <= rest_d;
                  cnt        <= CW'(WIDTH-1);
                  ready      <= 1'b0;
                  sout       <= nbit_d;
                  sout_valid <= 1'b1;
                  done       <= 1'b0;
`ifdef PISO_PARITY_EN
                  par        <= ^d;
`endif
               end
            end
            SHIFT: begin
               if (cnt != '0) begin
                  sreg <= rest_s;
                  sout <= nbit_s;
                  cnt  <= cnt - 1'b1;
`ifdef PISO_PARITY_EN
                  done <= 1'b0;
`else
                  // the bit going out next is the last one of the word
                  done <= (cnt == CW'(1));
`endif
               end else begin
`ifdef PISO_PARITY_EN
                  state <= PARITY;
                  sout  <= par;
                  done  <= 1'b1;
`else
                  state      <= IDLE;
                  ready      <= 1'b1;
                  sout       <= 1'b0;
                  sout_valid <= 1'b0;
                  done       <= 1'b0;
`endif
               end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
               state      <= IDLE;
               ready      <= 1'b1;
               sout       <= 1'b0;
               sout_valid <= 1'b0;
               done       <= 1'b0;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule
